fir_avg_out_stage: RTL
======================

# fir_avg_out_stage

Output stage placed directly downstream of the 4-tap signed averaging FIR. It takes the FIR's raw w+2-bit tap sum and divides it by 4 with round-half-up to form the true w-bit average. It suppresses the warm-up samples produced while the tap line fills, then buffers results in a small first-word-fall-through FIFO behind a valid/ready interface. Overflow is reported through a sticky flag and a drop counter.

## Interface
- `w`, 16, operand width; matches the FIR's `w`; FIR sum input is w+2 bits.
- `DEPTH`, 4, FIFO entries; must be a power of two, ≥2.
- `WARMUP`, 4, number of valid input samples discarded after reset or clear.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear: empties the FIFO, clears flags, restarts warm-up.
- `s`  in  signed w+2  FIR tap-sum output.
- `s_valid`  in  1  `s` carries a new sum this cycle.
- `m_data`  out  signed w  averaged sample at the FIFO head.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `ovf`  out  1  sticky; set when a post-warm-up sample is dropped because the FIFO is full.
- `drop_cnt`  out  8  dropped-sample count; saturates at 255.

## Operation
- **Arithmetic**
  - Compute `avg = (s + 2) >>> 2` in w+2 bits (arithmetic shift), then keep the low w bits.
  - Input range [-2^(w+1), 2^(w+1)-4] maps to [-2^(w-1), 2^(w-1)-1], so no saturation is needed.
  - Any `s` outside that range is a protocol violation; the result is truncated and an assertion fires.
- **State machine** (2 states)
  - WARM: on each `s_valid`, increment `warm_cnt`.
  - WARM → RUN: when `warm_cnt` reaches WARMUP-1 and `s_valid` = 1. That sample is still discarded, so exactly WARMUP samples are dropped.
  - RUN: every `s_valid` sample is a push candidate.
  - RUN → WARM: only on `clr` or reset.
  - When WARMUP = 0, start in RUN.
- **Push and pop**
  - push = RUN & `s_valid` & (not full | pop).
  - pop = `m_valid` & `m_ready`.
- **Boundary conditions**
  - Full, push, and pop in the same cycle: both occur and `count` is unchanged.
  - Full with no pop: the sample is dropped, `ovf` ← 1, and `drop_cnt` increments unless it is at 255.
  - Empty with `m_ready` = 1: no pop. `m_data` holds its last value and must not be used while `m_valid` = 0.
  - Read and write pointers wrap modulo DEPTH.
  - `ovf` clears only on `clr` or reset.
- **`clr` priority**
  - `clr` overrides any push or pop in the same cycle.
  - Next state: WARM, `warm_cnt` = 0, FIFO empty, `ovf` = 0, `drop_cnt` = 0.
  - FIFO storage contents are not cleared.

## Timing
- **Reset values** (`reset_n` low, asynchronous): `m_valid` 0, `m_data` 0, `count` 0, `ovf` 0, `drop_cnt` 0, state WARM, pointers 0, `warm_cnt` 0.
- **Mid-operation reset**: asserting `reset_n` mid-stream clears all state immediately, without waiting for a clock edge. Deassertion takes effect at the next edge.
- **Latency**: a sample pushed at edge k into an empty FIFO shows `m_valid` = 1 and `m_data` = avg after edge k, i.e. one cycle of latency.
- **Downstream timing**: `m_data` and `m_valid` depend only on registered state; there is no combinational path from `s` to `m_data`.
- **Consumer handshake**: a word is consumed at the edge where `m_valid` & `m_ready` = 1. The next entry, if any, appears after that same edge.
- **Throughput**: one sample per cycle sustained when `m_ready` is held high.

## Test plan
1. **Warm-up**: after reset, drive 4 valid samples with `s` = 100. Require `m_valid` = 0 throughout. On the 5th sample with `s` = 100, require `m_valid` = 1 and `m_data` = 25 one cycle later.
2. **Rounding** (post-warm-up, `m_ready` = 1): `s` = 6, 5, 7, -5, -6, -7 must produce `m_data` = 2, 1, 2, -1, -1, -2.
3. **Extremes** (w = 16): `s` = 131068 → 32767 (0x7FFF); `s` = -131072 → -32768 (0x8000); `s` = -2 → 0.
4. **Overflow**: with `m_ready` = 0, push 5 post-warm-up samples with `s` = 4, 8, 12, 16, 20. Require `count` = 4, `ovf` = 1, `drop_cnt` = 1, `m_data` = 1. Then raise `m_ready` and require the output sequence 1, 2, 3, 4, after which `m_valid` = 0.
5. **Full with simultaneous push and pop**: with the FIFO full, pulse `m_ready` = 1 while `s_valid` = 1. Require `count` stays 4, `ovf` stays 0, and the new sample lands at the tail.
6. **Reset and clear mid-stream**:
   - Assert `reset_n` = 0 between clock edges with `count` = 3. Require `m_valid`, `count`, and `ovf` to go to 0 immediately.
   - Repeat with `clr`; the effect occurs at the next edge.
   - In both cases, require that 4 fresh samples are discarded again before any output.

Source files
------------

// File: rtl/fir_avg_out_stage.sv
// fir_avg_out_stage: divides the 4-tap FIR sum by four with round-half-up,
// discards the warm-up samples, and queues results in a small FWFT FIFO.
module fir_avg_out_stage #(
  parameter int w      = 16,
  parameter int DEPTH  = 4,
  parameter int WARMUP = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic signed [w+1:0]        s,
  input  logic                       s_valid,
  output logic signed [w-1:0]        m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  localparam logic [WCW-1:0]       WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CW-1:0]        FULL_CNT  = CW'(DEPTH);
  localparam logic signed [w+1:0]  S_MAX     = (w+2)'((2 ** (w + 1)) - 4);

  typedef enum logic {WARM, RUN} state_t;

  // With no warm-up samples to discard the stage starts straight in RUN.
  localparam state_t INIT_STATE = (WARMUP == 0) ? RUN : WARM;

  state_t               state, state_next;
  logic [WCW-1:0]       warm_cnt, warm_next;
  logic [PW-1:0]        wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]        count_next;
  logic signed [w-1:0]  mem [DEPTH];
  logic signed [w-1:0]  head_next;
  logic signed [w+1:0]  rounded;
  logic signed [w-1:0]  avg;
  logic                 run, full, pop, push, drop;

  // Round-half-up divide by four: add half an LSB of the result, then shift
  // arithmetically so negative sums round towards +infinity on ties.
  assign rounded = s + $signed((w+2)'(2));
  assign avg     = w'(rounded >>> 2);

  assign run     = (state == RUN);
  assign m_valid = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = m_valid & m_ready;
  assign push    = run & s_valid & (~full | pop);
  assign drop    = run & s_valid & full & ~pop;
  assign rd_next = rd_ptr + PW'(pop);

  // Occupancy and the next FIFO head; the head is registered so m_data never
  // depends combinationally on s, and it holds its last value when empty.
  always_comb begin
    count_next = count;
    head_next  = m_data;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_next)) begin
        head_next = avg;
      end else begin
        head_next = mem[rd_next];
      end
    end
  end

  // Warm-up sequencer: counts discarded samples, the last one moves to RUN.
  always_comb begin
    state_next = state;
    warm_next  = warm_cnt;
    case (state)
      WARM: begin
        if (s_valid) begin
          if (warm_cnt == WARM_LAST) begin
            state_next = RUN;
            warm_next  = '0;
          end else begin
            warm_next = warm_cnt + 1'b1;
          end
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = INIT_STATE;
      end
    endcase
    if (clr) begin
      state_next = INIT_STATE;
      warm_next  = '0;
    end
  end

  // State register for the warm-up sequencer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT_STATE;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_next;
    end
  end

  // FIFO storage; deliberately not cleared by reset or clr.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= avg;
    end
  end

  // Pointers, occupancy, head register and overflow bookkeeping; clr wins
  // over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      m_data   <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      m_data <= head_next;
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  // Sums above 2^(w+1)-4 cannot come from four in-range taps and would wrap.
  s_range_check: assert property (@(posedge clk) disable iff (!reset_n)
                                   s_valid |-> (s <= S_MAX));

endmodule
